fetch_unit: RTL and testbench

//   Instruction-fetch stage feeding the decoder/control unit. Owns the PC, issues
//   in-order requests to instruction memory, buffers returned words in a small FIFO,
//   and presents {instr, pc} plus split opcode/funct3/funct7 fields to decode over valid/ready.

---
 rtl/riscv_pkg.sv | 26 ++
 rtl/fetch_fifo.sv | 48 ++++
 rtl/fetch_unit.sv | 146 ++++++++++++++
 tb/tb_fetch_unit.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 constants, instruction field positions and fetch FSM encoding.
package riscv_pkg;

   localparam int XLEN    = 32;
   localparam int INSTR_W = 32;

   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] JAL    = 7'b1101111;

   localparam int OPCODE_LSB = 0;
   localparam int OPCODE_MSB = 6;
   localparam int FUNCT3_LSB = 12;
   localparam int FUNCT3_MSB = 14;
   localparam int FUNCT7_LSB = 25;
   localparam int FUNCT7_MSB = 31;

   typedef logic [0:0] fetch_state_t;
   localparam fetch_state_t RUN   = 1'b0;
   localparam fetch_state_t DRAIN = 1'b1;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; push and pop may coincide at any count, including full.
module fetch_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   input  logic                       flush,
   output logic [WIDTH-1:0]           head,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, in-order imem requests, instruction buffer, redirect flush.
// Optional FETCH_PERF_EN adds perf_fetched / perf_stall / perf_flush counters.
//
//   state | meaning
//   RUN   | issue requests within credit, push responses into the buffer
//   DRAIN | wrong-path responses still in flight; discard them, issue nothing
module fetch_unit
   import riscv_pkg::*;
#(
   parameter int              XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [31:0]     id_instr,
   output logic [XLEN-1:0] id_pc,
   output logic [6:0]      id_opcode,
   output logic [2:0]      id_funct3,
   output logic [6:0]      id_funct7
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]     perf_fetched,
   output logic [31:0]     perf_stall,
   output logic [31:0]     perf_flush
`endif
);
   localparam int CW = $clog2(FIFO_DEPTH+1);
   localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

   fetch_state_t    state;
   logic [XLEN-1:0] pc;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   drop;
   logic [CW-1:0]   out_after_rsp;

   logic            rsp_fire;
   logic            req_fire;
   logic            id_pop;
   logic            ibuf_push;
   logic            tag_pop;

   logic [INSTR_W+XLEN-1:0] ibuf_head;
   logic [CW-1:0]           ibuf_count;
   logic                    ibuf_full;
   logic                    ibuf_empty;
   logic [XLEN-1:0]         tag_head;
   logic [CW-1:0]           tag_count;
   logic                    tag_full;
   logic                    tag_empty;
   logic [INSTR_W-1:0]      head_instr;
   logic [XLEN-1:0]         head_pc;

   assign rsp_fire      = imem_rsp_valid && (outstanding != '0);
   assign out_after_rsp = outstanding - CW'(rsp_fire);

   // In RUN the tag queue holds exactly the outstanding requests, so it doubles as the credit count.
   assign imem_req_valid = !reset && (state == RUN) && !redirect_valid && !tag_full &&
                           (({1'b0, ibuf_count} + {1'b0, tag_count}) < DEPTH_C);
   assign imem_req_addr  = pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign id_pop    = id_valid && id_ready;
   assign tag_pop   = rsp_fire && (state == RUN) && !tag_empty;
   assign ibuf_push = tag_pop && !redirect_valid && (!ibuf_full || id_pop);

   fetch_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_tag (
      .clk       (clk),
      .reset     (reset),
      .push      (req_fire),
      .push_data (pc),
      .pop       (tag_pop),
      .flush     (redirect_valid),
      .head      (tag_head),
      .count     (tag_count),
      .full      (tag_full),
      .empty     (tag_empty)
   );

   fetch_fifo #(.WIDTH(INSTR_W+XLEN), .DEPTH(FIFO_DEPTH)) u_ibuf (
      .clk       (clk),
      .reset     (reset),
      .push      (ibuf_push),
      .push_data ({imem_rsp_data, tag_head}),
      .pop       (id_pop),
      .flush     (redirect_valid),
      .head      (ibuf_head),
      .count     (ibuf_count),
      .full      (ibuf_full),
      .empty     (ibuf_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= RUN;
         pc          <= RESET_PC;
         outstanding <= '0;
         drop        <= '0;
      end else if (redirect_valid) begin
         // Every request still in flight after this cycle belongs to the wrong path.
         pc          <= redirect_pc & ~XLEN'(3);
         outstanding <= out_after_rsp;
         drop        <= out_after_rsp;
         state       <= (out_after_rsp != '0) ? DRAIN : RUN;
      end else begin
         outstanding <= outstanding + CW'(req_fire) - CW'(rsp_fire);
         if (req_fire) pc <= pc + XLEN'(4);
         if ((state == DRAIN) && rsp_fire) begin
            drop <= drop - 1'b1;
            if (drop == CW'(1)) state <= RUN;
         end
      end
   end

   assign {head_instr, head_pc} = ibuf_head;
   assign id_valid  = !reset && !ibuf_empty;
   assign id_instr  = id_valid ? head_instr : '0;
   assign id_pc     = id_valid ? head_pc : '0;
   assign id_opcode = id_instr[OPCODE_MSB:OPCODE_LSB];
   assign id_funct3 = id_instr[FUNCT3_MSB:FUNCT3_LSB];
   assign id_funct7 = id_instr[FUNCT7_MSB:FUNCT7_LSB];

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_fetched <= '0;
         perf_stall   <= '0;
         perf_flush   <= '0;
      end else begin
         perf_fetched <= perf_fetched + 32'(id_pop);
         perf_stall   <= perf_stall + 32'(!id_valid);
         perf_flush   <= perf_flush + 32'(redirect_valid);
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle-level imem model, pop/request recorders, per-feature tasks.
module tb_fetch_unit;
   import riscv_pkg::*;

   localparam int DEPTH = 2;

   logic        clk;
   logic        reset;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_valid, id_ready;
   logic [31:0] id_instr, id_pc;
   logic [6:0]  id_opcode, id_funct7;
   logic [2:0]  id_funct3;

   logic        w_req_valid, w_id_valid;
   logic [31:0] w_req_addr, w_id_instr, w_id_pc;
   logic [6:0]  w_opcode, w_funct7;
   logic [2:0]  w_funct3;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched, perf_stall, perf_flush;
   logic [31:0] w_perf_fetched, w_perf_stall, w_perf_flush;
`endif

   fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
      .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7(id_funct7)
`ifdef FETCH_PERF_EN
      , .perf_fetched(perf_fetched), .perf_stall(perf_stall), .perf_flush(perf_flush)
`endif
   );

   fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(DEPTH)) dut_wrap (
      .clk(clk), .reset(reset),
      .imem_req_valid(w_req_valid), .imem_req_ready(1'b1), .imem_req_addr(w_req_addr),
      .imem_rsp_valid(1'b0), .imem_rsp_data(32'h0),
      .redirect_valid(1'b0), .redirect_pc(32'h0),
      .id_valid(w_id_valid), .id_ready(1'b0), .id_instr(w_id_instr), .id_pc(w_id_pc),
      .id_opcode(w_opcode), .id_funct3(w_funct3), .id_funct7(w_funct7)
`ifdef FETCH_PERF_EN
      , .perf_fetched(w_perf_fetched), .perf_stall(w_perf_stall), .perf_flush(w_perf_flush)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'h5A3C_7013;
   endfunction

   // imem model: in-order responses, each at least lat cycles after its accept
   int          lat = 1;
   int          cycle_n = 0;
   int          due_q[$];
   logic [31:0] addr_q[$];

   initial begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      forever begin
         @(negedge clk);
         cycle_n++;
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = '0;
         if (reset) begin
            due_q.delete();
            addr_q.delete();
         end else begin
            if (addr_q.size() > 0 && due_q[0] <= cycle_n) begin
               imem_rsp_valid = 1'b1;
               imem_rsp_data  = instr_of(addr_q[0]);
               void'(addr_q.pop_front());
               void'(due_q.pop_front());
            end
            if (imem_req_valid && imem_req_ready) begin
               addr_q.push_back(imem_req_addr);
               due_q.push_back(cycle_n + lat);
            end
         end
      end
   end

   // per-cycle snapshot and recorders
   logic        s_req_valid, s_id_valid, s_rsp_valid, s2_req_valid;
   logic [31:0] s_req_addr, s_id_pc, s_id_instr, s2_req_addr;
   logic [6:0]  s_opcode, s_funct7;
   logic [2:0]  s_funct3;
   logic [31:0] pop_pc_q[$];
   logic [31:0] pop_instr_q[$];
   logic [31:0] req_q[$];
   int          sb_fetched, sb_stall, sb_flush;

   task automatic cyc();
      @(negedge clk);
      #1;
      s_req_valid  = imem_req_valid;
      s_req_addr   = imem_req_addr;
      s_id_valid   = id_valid;
      s_id_pc      = id_pc;
      s_id_instr   = id_instr;
      s_opcode     = id_opcode;
      s_funct3     = id_funct3;
      s_funct7     = id_funct7;
      s_rsp_valid  = imem_rsp_valid;
      s2_req_valid = w_req_valid;
      s2_req_addr  = w_req_addr;
      if (!reset && id_valid && id_ready) begin
         pop_pc_q.push_back(id_pc);
         pop_instr_q.push_back(id_instr);
      end
      if (!reset && imem_req_valid && imem_req_ready) req_q.push_back(imem_req_addr);
      if (reset) begin
         sb_fetched = 0; sb_stall = 0; sb_flush = 0;
      end else begin
         sb_fetched += int'(id_valid && id_ready);
         sb_stall   += int'(!id_valid);
         sb_flush   += int'(redirect_valid);
      end
      if (int'(dut.u_ibuf.count) > DEPTH) begin
         failures++;
         $display("FAIL fifo_overflow count=%0d max=%0d", dut.u_ibuf.count, DEPTH);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset(input int lat_i, input logic ready_i);
      reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
      imem_req_ready = 1'b1; id_ready = ready_i; lat = lat_i;
      cyc(); cyc();
      reset = 1'b0;
      pop_pc_q.delete(); pop_instr_q.delete(); req_q.delete();
   endtask

   task automatic test_reset();
      reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
      imem_req_ready = 1'b1; id_ready = 1'b0; lat = 1;
      cyc(); cyc();
      checks++; if (s_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b want=0", s_req_valid); end
      checks++; if (s_id_valid !== 1'b0) begin failures++; $display("FAIL reset_id_valid got=%b want=0", s_id_valid); end
      checks++; if (s_id_pc !== 32'h0 || s_id_instr !== 32'h0) begin failures++; $display("FAIL reset_id_zero pc=%h instr=%h want=0", s_id_pc, s_id_instr); end
      checks++; if (s2_req_valid !== 1'b0) begin failures++; $display("FAIL reset_wrap_req_valid got=%b want=0", s2_req_valid); end
      reset = 1'b0;
      pop_pc_q.delete(); pop_instr_q.delete(); req_q.delete();
   endtask

   task automatic test_first_fetch();
      logic [31:0] w0;
      w0 = instr_of(32'h0);
      cyc();
      checks++; if (s_req_valid !== 1'b1 || s_req_addr !== 32'h0) begin failures++; $display("FAIL first_req0 valid=%b addr=%h want 1/0", s_req_valid, s_req_addr); end
      checks++; if (s2_req_valid !== 1'b1 || s2_req_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_req0 valid=%b addr=%h want 1/fffffffc", s2_req_valid, s2_req_addr); end
      checks++; if (s_id_valid !== 1'b0) begin failures++; $display("FAIL first_id_early c1 got=%b want=0", s_id_valid); end
      cyc();
      checks++; if (s_req_valid !== 1'b1 || s_req_addr !== 32'h4) begin failures++; $display("FAIL first_req1 valid=%b addr=%h want 1/4", s_req_valid, s_req_addr); end
      checks++; if (s2_req_valid !== 1'b1 || s2_req_addr !== 32'h0) begin failures++; $display("FAIL wrap_req1 valid=%b addr=%h want 1/0", s2_req_valid, s2_req_addr); end
      checks++; if (s_id_valid !== 1'b0) begin failures++; $display("FAIL first_id_early c2 got=%b want=0", s_id_valid); end
      cyc();
      checks++; if (s_id_valid !== 1'b1 || s_id_pc !== 32'h0 || s_id_instr !== w0) begin failures++; $display("FAIL first_id valid=%b pc=%h instr=%h want 1/0/%h", s_id_valid, s_id_pc, s_id_instr, w0); end
      checks++; if (s_opcode !== w0[6:0] || s_funct3 !== w0[14:12] || s_funct7 !== w0[31:25]) begin failures++; $display("FAIL first_fields op=%h f3=%h f7=%h want %h/%h/%h", s_opcode, s_funct3, s_funct7, w0[6:0], w0[14:12], w0[31:25]); end
      checks++; if (s_req_valid !== 1'b0) begin failures++; $display("FAIL first_credit_stop got=%b want=0", s_req_valid); end
      checks++; if (s2_req_valid !== 1'b0) begin failures++; $display("FAIL wrap_credit_stop got=%b want=0", s2_req_valid); end
   endtask

   task automatic test_stall();
      logic ok;
      repeat (10) cyc();
      checks++; if (req_q.size() != DEPTH || s_req_valid !== 1'b0) begin failures++; $display("FAIL stall_req_count got=%0d valid=%b want %0d/0", req_q.size(), s_req_valid, DEPTH); end
      checks++; if (s_id_valid !== 1'b1 || s_id_pc !== 32'h0) begin failures++; $display("FAIL stall_head valid=%b pc=%h want 1/0", s_id_valid, s_id_pc); end
      id_ready = 1'b1;
      repeat (20) cyc();
      ok = 1'b1;
      for (int i = 0; i < pop_pc_q.size(); i++)
         if (pop_pc_q[i] !== 32'(i*4) || pop_instr_q[i] !== instr_of(32'(i*4))) ok = 1'b0;
      checks++; if (!ok || pop_pc_q.size() < 6) begin failures++; $display("FAIL stall_pop_seq pops=%0d in_order=%b want >=6/1", pop_pc_q.size(), ok); end
      id_ready = 1'b0;
   endtask

   task automatic test_toggle();
      logic ok_pop, ok_req;
      apply_reset(3, 1'b1);
      for (int i = 0; i < 40; i++) begin
         imem_req_ready = (i % 2 == 0);
         cyc();
      end
      imem_req_ready = 1'b1;
      ok_pop = 1'b1;
      for (int i = 0; i < pop_pc_q.size(); i++)
         if (pop_pc_q[i] !== 32'(i*4) || pop_instr_q[i] !== instr_of(32'(i*4))) ok_pop = 1'b0;
      ok_req = 1'b1;
      for (int i = 0; i < req_q.size(); i++)
         if (req_q[i] !== 32'(i*4)) ok_req = 1'b0;
      checks++; if (!ok_pop || pop_pc_q.size() < 4) begin failures++; $display("FAIL toggle_pop_seq pops=%0d in_order=%b want >=4/1", pop_pc_q.size(), ok_pop); end
      checks++; if (!ok_req || req_q.size() < pop_pc_q.size()) begin failures++; $display("FAIL toggle_req_seq reqs=%0d in_order=%b want >=%0d/1", req_q.size(), ok_req, pop_pc_q.size()); end
   endtask

   task automatic test_redirect();
      logic ok;
      apply_reset(3, 1'b0);
      cyc();
      cyc();
      checks++; if (req_q.size() != 2) begin failures++; $display("FAIL redir_setup reqs=%0d want=2", req_q.size()); end
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      cyc();
      redirect_valid = 1'b0;
      checks++; if (s_req_valid !== 1'b0) begin failures++; $display("FAIL redir_no_issue got=%b want=0", s_req_valid); end
      checks++; if (dut.state !== DRAIN) begin failures++; $display("FAIL redir_state got=%b want=DRAIN", dut.state); end
      cyc();
      checks++; if (s_req_valid !== 1'b0 || s_id_valid !== 1'b0) begin failures++; $display("FAIL drain_c4 req=%b id=%b want 0/0", s_req_valid, s_id_valid); end
      cyc();
      checks++; if (s_req_valid !== 1'b0 || s_id_valid !== 1'b0) begin failures++; $display("FAIL drain_c5 req=%b id=%b want 0/0", s_req_valid, s_id_valid); end
      cyc();
      checks++; if (s_req_valid !== 1'b1 || s_req_addr !== 32'h100 || s_id_valid !== 1'b0) begin failures++; $display("FAIL drain_exit req=%b addr=%h id=%b want 1/100/0", s_req_valid, s_req_addr, s_id_valid); end
      id_ready = 1'b1;
      repeat (15) cyc();
      ok = 1'b1;
      for (int i = 0; i < pop_pc_q.size(); i++)
         if (pop_pc_q[i] !== 32'h100 + 32'(i*4) || pop_instr_q[i] !== instr_of(32'h100 + 32'(i*4))) ok = 1'b0;
      checks++; if (!ok || pop_pc_q.size() < 3) begin failures++; $display("FAIL redir_pop_seq pops=%0d from_100=%b want >=3/1", pop_pc_q.size(), ok); end
   endtask

   task automatic test_redirect_align();
      logic [31:0] p0, p1, p2;
      apply_reset(1, 1'b1);
      cyc();
      cyc();
      redirect_valid = 1'b1; redirect_pc = 32'h103;
      cyc();
      redirect_valid = 1'b0;
      checks++; if (s_id_valid !== 1'b1 || s_id_pc !== 32'h0 || s_rsp_valid !== 1'b1) begin failures++; $display("FAIL align_coincide id=%b pc=%h rsp=%b want 1/0/1", s_id_valid, s_id_pc, s_rsp_valid); end
      checks++; if (dut.state !== RUN) begin failures++; $display("FAIL align_state got=%b want=RUN", dut.state); end
      cyc();
      checks++; if (s_req_valid !== 1'b1 || s_req_addr !== 32'h100 || s_id_valid !== 1'b0) begin failures++; $display("FAIL align_req req=%b addr=%h id=%b want 1/100/0", s_req_valid, s_req_addr, s_id_valid); end
      repeat (10) cyc();
      p0 = (pop_pc_q.size() > 0) ? pop_pc_q[0] : 32'hDEAD_BEEF;
      p1 = (pop_pc_q.size() > 1) ? pop_pc_q[1] : 32'hDEAD_BEEF;
      p2 = (pop_pc_q.size() > 2) ? pop_pc_q[2] : 32'hDEAD_BEEF;
      checks++; if (p0 !== 32'h0 || p1 !== 32'h100 || p2 !== 32'h104) begin failures++; $display("FAIL align_pops got=%h,%h,%h want 0,100,104", p0, p1, p2); end
   endtask

   task automatic test_perf();
      int i;
      apply_reset(2, 1'b1);
      i = 0;
      while ((pop_pc_q.size() < 50 || i <= 33) && i < 2000) begin
         id_ready = (i % 3 != 2);
         redirect_valid = (i == 7 || i == 20 || i == 33);
         redirect_pc = 32'h200 + 32'(i*16);
         cyc();
         i++;
      end
      redirect_valid = 1'b0;
      checks++; if (pop_pc_q.size() < 50) begin failures++; $display("FAIL perf_timeout pops=%0d want >=50", pop_pc_q.size()); end
`ifdef FETCH_PERF_EN
      checks++; if (perf_fetched !== 32'(sb_fetched)) begin failures++; $display("FAIL perf_fetched got=%0d want=%0d", perf_fetched, sb_fetched); end
      checks++; if (perf_stall !== 32'(sb_stall)) begin failures++; $display("FAIL perf_stall got=%0d want=%0d", perf_stall, sb_stall); end
      checks++; if (perf_flush !== 32'(sb_flush)) begin failures++; $display("FAIL perf_flush got=%0d want=%0d", perf_flush, sb_flush); end
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
      imem_req_ready = 1'b1; id_ready = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_first_fetch();
      test_stall();
      test_toggle();
      test_redirect();
      test_redirect_align();
      test_perf();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
